// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared sizes, FSM state and register type for the 16x8 register bank.
package reg_bank_pkg;
  localparam int NREGS  = 16;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;
  typedef enum logic {S_IDLE, S_CLEAR} rb_state_t;
  typedef logic [WIDTH-1:0] reg_t;
endpackage

// File: rtl/reg_bank_16x8_reg_cell.sv
// reg_cell: one WIDTH-bit register with sync active-low reset, load, and a clear that wins over load.
module reg_cell
  import reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ld_i,
  input  logic clr_i,
  input  reg_t d_i,
  output reg_t q_o
);
  reg_t q_q, q_d;
  always_comb q_d = clr_i ? '0 : ld_i ? d_i : q_q;
  always_ff @(posedge clk)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/reg_bank_16x8.sv
// reg_bank_16x8: 16x8 register bank with write port, dirty mask and one-register-per-cycle clear sweep.
// Define REGBANK_R0_ZERO_EN to hardwire register 0 to zero.
module reg_bank_16x8
  import reg_bank_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  input  logic                   clr_req,
  output logic                   busy,
  output logic [NREGS-1:0]       dirty,
  output logic [NREGS*WIDTH-1:0] regs_out
);
  rb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [NREGS-1:0]  dirty_q, dirty_d;
  logic              we, sweep;
  assign we       = wr_en && state_q == S_IDLE;
  assign sweep    = state_q == S_CLEAR;
  assign wr_ready = !sweep;
  assign busy     = sweep;
  assign dirty    = dirty_q;
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (!sweep) begin
      state_d   = clr_req ? S_CLEAR : S_IDLE;
      clr_ptr_d = '0;
    end else begin
      state_d   = clr_ptr_q == ADDR_W'(NREGS - 1) ? S_IDLE : S_CLEAR;
      clr_ptr_d = clr_ptr_q == ADDR_W'(NREGS - 1) ? '0 : clr_ptr_q + 1'b1;
    end
  end
  always_comb begin
    dirty_d = dirty_q;
    if (we)    dirty_d[wr_addr]   = 1'b1;
    if (sweep) dirty_d[clr_ptr_q] = 1'b0;
`ifdef REGBANK_R0_ZERO_EN
    dirty_d[0] = 1'b0;
`endif
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      clr_ptr_q <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      dirty_q   <= dirty_d;
    end
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
`ifdef REGBANK_R0_ZERO_EN
    if (i == 0) begin : g_zero
      assign regs_out[WIDTH-1:0] = '0;
    end else begin : g_cell
      reg_cell u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (we && wr_addr == ADDR_W'(i)),
        .clr_i (sweep && clr_ptr_q == ADDR_W'(i)),
        .d_i   (wr_data),
        .q_o   (regs_out[i*WIDTH +: WIDTH])
      );
    end
`else
    reg_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (we && wr_addr == ADDR_W'(i)),
      .clr_i (sweep && clr_ptr_q == ADDR_W'(i)),
      .d_i   (wr_data),
      .q_o   (regs_out[i*WIDTH +: WIDTH])
    );
`endif
  end
endmodule

// File: tb/tb_reg_bank_16x8.sv
// tb_reg_bank_16x8: directed self-checking bench for reg_bank_16x8.
module tb_reg_bank_16x8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [7:0]   wr_data = '0;
  logic         wr_ready;
  logic         clr_req = 1'b0;
  logic         busy;
  logic [15:0]  dirty;
  logic [127:0] regs_out;
  int n_assert = 0;
  int n_fail = 0;
`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  reg_bank_16x8 dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_req(clr_req), .busy(busy), .dirty(dirty), .regs_out(regs_out)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] rb(int i);
    return regs_out[i*8 +: 8];
  endfunction
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic pulse_clr();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check(tag, 128'(busy), 128'(0));
  endtask
  initial begin
    logic [15:0] full;
    int n;
    full = R0Z ? 16'hfffe : 16'hffff;
    step(); step();
    check("rst_regs", regs_out, '0);
    check("rst_dirty", 128'(dirty), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(1));
    rst_n = 1'b1;
    write(4'd3, 8'h5A);
    write(4'd15, 8'hFF);
    check("wr_r3", 128'(rb(3)), 128'(8'h5A));
    check("wr_r15", 128'(rb(15)), 128'(8'hFF));
    check("wr_dirty", 128'(dirty), 128'(16'h8008));
    for (int i = 0; i < 16; i++) write(4'(i), 8'(8'h10 + i));
    check("fill_dirty", 128'(dirty), 128'(full));
    check("fill_r9", 128'(rb(9)), 128'(8'h19));
    check("fill_r0", 128'(rb(0)), 128'(R0Z ? 8'h00 : 8'h10));
    pulse_clr();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sweep_busy_%0d", k), 128'(busy), 128'(1));
      check($sformatf("sweep_wr_ready_%0d", k), 128'(wr_ready), 128'(0));
      if (k < 15) check($sformatf("sweep_pending_%0d", k + 1), 128'(rb(k + 1)), 128'(8'h10 + k + 1));
      step();
      check($sformatf("sweep_clr_%0d", k), 128'(rb(k)), 128'(0));
    end
    check("sweep_end_busy", 128'(busy), 128'(0));
    check("sweep_end_ready", 128'(wr_ready), 128'(1));
    check("sweep_end_dirty", 128'(dirty), 128'(0));
    check("sweep_end_regs", regs_out, '0);
    write(4'd7, 8'h44);
    pulse_clr();
    for (int k = 0; k < 9; k++) step();
    check("busy_r7_cleared", 128'(rb(7)), 128'(0));
    write(4'd7, 8'h33);
    check("busy_wr_dropped", 128'(rb(7)), 128'(0));
    check("busy_wr_dirty", 128'(dirty[7]), 128'(0));
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wait_idle("wait_idle_a");
    check("post_busy_r7", 128'(rb(7)), 128'(0));
    check("post_busy_dirty", 128'(dirty), 128'(0));
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'hAA; clr_req = 1'b1;
    step();
    wr_en = 1'b0; clr_req = 1'b0;
    check("same_edge_r2", 128'(rb(2)), 128'(8'hAA));
    check("same_edge_busy", 128'(busy), 128'(1));
    check("same_edge_dirty", 128'(dirty), 128'(16'h0004));
    step(); step();
    check("same_edge_r2_hold", 128'(rb(2)), 128'(8'hAA));
    step();
    check("same_edge_r2_clr", 128'(rb(2)), 128'(0));
    wait_idle("wait_idle_b");
    write(4'd9, 8'h99);
    write(4'd12, 8'hC3);
    pulse_clr();
    for (int k = 0; k < 5; k++) step();
    check("mid_sweep_r9", 128'(rb(9)), 128'(8'h99));
    rst_n = 1'b0;
    step();
    check("mid_rst_regs", regs_out, '0);
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_ready", 128'(wr_ready), 128'(1));
    check("mid_rst_dirty", 128'(dirty), 128'(0));
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 128'(busy), 128'(0));
    pulse_clr();
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check("full_sweep_len", 128'(n), 128'(16));
    write(4'd0, 8'h77);
    check("r0_value", 128'(rb(0)), 128'(R0Z ? 8'h00 : 8'h77));
    check("r0_dirty", 128'(dirty[0]), 128'(R0Z ? 1'b0 : 1'b1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
